mdu_sequencer: RTL

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_pkg.sv | 60 ++++++
 rtl/mdu_lane_pack.sv | 42 ++++
 rtl/mdu_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: opcodes, SIMD lane modes,
// FSM states and small opcode-decoding helpers.
package mdu_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_SIMD_DATA_WIDTH = 64;
    localparam int DEF_MUL_LAT         = 2;

    localparam int LANE32_W = 32;
    localparam int LANE16_W = 16;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;

    localparam logic [1:0] SIMD_SCALAR     = 2'b00;
    localparam logic [1:0] SIMD_LANE32     = 2'b01;
    localparam logic [1:0] SIMD_LANE16     = 2'b10;
    localparam logic [1:0] SIMD_SCALAR_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op[3:2] == 2'b01);
    endfunction

    function automatic logic is_signed_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // {s1 signed, s2 signed}
    function automatic logic [1:0] mul_sign_of(input logic [3:0] op);
        logic [1:0] sg;
        case (op)
            OP_MULH:   sg = 2'b11;
            OP_MULHSU: sg = 2'b10;
            default:   sg = 2'b00;
        endcase
        return sg;
    endfunction

endpackage

// File: rtl/mdu_lane_pack.sv
// Selects the low or high half of each lane product from the external multiplier
// and packs the halves into one SIMD result word, preserving lane order.
module mdu_lane_pack #(
    parameter int DATA_WIDTH      = 32,
    parameter int SIMD_DATA_WIDTH = 64
) (
    input  logic [2*SIMD_DATA_WIDTH-1:0] i_product,
    input  logic                         i_high,
    input  logic [1:0]                   i_simd_ctl,
    output logic [SIMD_DATA_WIDTH-1:0]   o_data
);
    import mdu_pkg::*;

    localparam int N32 = SIMD_DATA_WIDTH / LANE32_W;
    localparam int N16 = SIMD_DATA_WIDTH / LANE16_W;

    // lane product i lives at [i*2W +: 2W]; its result half goes to [i*W +: W]
    always_comb begin
        o_data = '0;
        case (i_simd_ctl)
            SIMD_LANE32: begin
                for (int i = 0; i < N32; i++) begin
                    o_data[i*LANE32_W +: LANE32_W] = i_high ?
                        i_product[i*2*LANE32_W + LANE32_W +: LANE32_W] :
                        i_product[i*2*LANE32_W +: LANE32_W];
                end
            end
            SIMD_LANE16: begin
                for (int i = 0; i < N16; i++) begin
                    o_data[i*LANE16_W +: LANE16_W] = i_high ?
                        i_product[i*2*LANE16_W + LANE16_W +: LANE16_W] :
                        i_product[i*2*LANE16_W +: LANE16_W];
                end
            end
            default: begin
                o_data[DATA_WIDTH-1:0] = i_high ? i_product[DATA_WIDTH +: DATA_WIDTH] :
                                                  i_product[0 +: DATA_WIDTH];
            end
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Sequences multiply (scalar/SIMD) and divide operations onto external multiplier
// and divider units, handling divide special cases locally.
module mdu_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int SIMD_DATA_WIDTH = 64,
    parameter int MUL_LAT         = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_op,
    input  logic [SIMD_DATA_WIDTH-1:0]   in_s1,
    input  logic [SIMD_DATA_WIDTH-1:0]   in_s2,
    input  logic [1:0]                   in_simd_ctl,
    input  logic                         flush,
    output logic [SIMD_DATA_WIDTH-1:0]   mul_s1,
    output logic [SIMD_DATA_WIDTH-1:0]   mul_s2,
    output logic [1:0]                   mul_sign,
    output logic                         mul_start,
    input  logic [2*SIMD_DATA_WIDTH-1:0] mul_result,
    output logic [DATA_WIDTH:0]          div_s1,
    output logic [DATA_WIDTH:0]          div_s2,
    output logic                         div_start,
    input  logic                         div_done,
    input  logic [DATA_WIDTH:0]          div_quotient,
    input  logic [DATA_WIDTH:0]          div_remainder,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIMD_DATA_WIDTH-1:0]   out_data,
    output logic                         busy
);
    import mdu_pkg::*;

    localparam int CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
    localparam int XW = SIMD_DATA_WIDTH - DATA_WIDTH;

    mdu_state_e                  r_state, w_state_nxt;
    logic [CW-1:0]               r_cnt, w_cnt_nxt;
    logic [3:0]                  r_op, w_op_nxt;
    logic [1:0]                  r_simd, w_simd_nxt;
    logic [SIMD_DATA_WIDTH-1:0]  r_mul_s1, w_mul_s1_nxt, r_mul_s2, w_mul_s2_nxt;
    logic [1:0]                  r_mul_sign, w_mul_sign_nxt;
    logic                        r_mul_start, w_mul_start_nxt;
    logic [DATA_WIDTH:0]         r_div_s1, w_div_s1_nxt, r_div_s2, w_div_s2_nxt;
    logic                        r_div_start, w_div_start_nxt;
    logic [SIMD_DATA_WIDTH-1:0]  r_result, w_result_nxt;

    logic                        w_simd_lanes;
    logic                        w_div_signed;
    logic                        w_div_zero;
    logic                        w_div_ovf;
    logic [DATA_WIDTH:0]         w_div_a;
    logic [DATA_WIDTH:0]         w_div_b;
    logic [DATA_WIDTH:0]         w_div_sel;
    logic [SIMD_DATA_WIDTH-1:0]  w_packed;

    mdu_lane_pack #(
        .DATA_WIDTH      (DATA_WIDTH),
        .SIMD_DATA_WIDTH (SIMD_DATA_WIDTH)
    ) u_lane_pack (
        .i_product  (mul_result),
        .i_high     (r_op != OP_MUL),
        .i_simd_ctl (r_simd),
        .o_data     (w_packed)
    );

    assign w_simd_lanes = (in_simd_ctl == SIMD_LANE32) || (in_simd_ctl == SIMD_LANE16);
    assign w_div_signed = is_signed_div(in_op);
    assign w_div_a      = {w_div_signed & in_s1[DATA_WIDTH-1], in_s1[DATA_WIDTH-1:0]};
    assign w_div_b      = {w_div_signed & in_s2[DATA_WIDTH-1], in_s2[DATA_WIDTH-1:0]};
    assign w_div_zero   = (in_s2[DATA_WIDTH-1:0] == '0);
    assign w_div_ovf    = w_div_signed && (in_s2[DATA_WIDTH-1:0] == '1) &&
                          (in_s1[DATA_WIDTH-1:0] == {1'b1, {(DATA_WIDTH-1){1'b0}}});
    assign w_div_sel    = is_rem_op(r_op) ? div_remainder : div_quotient;

    // Next-state and next-register values; flush overrides everything at the end
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_op_nxt        = r_op;
        w_simd_nxt      = r_simd;
        w_mul_s1_nxt    = r_mul_s1;
        w_mul_s2_nxt    = r_mul_s2;
        w_mul_sign_nxt  = r_mul_sign;
        w_mul_start_nxt = 1'b0;
        w_div_s1_nxt    = r_div_s1;
        w_div_s2_nxt    = r_div_s2;
        w_div_start_nxt = 1'b0;
        w_result_nxt    = r_result;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_op_nxt   = in_op;
                    w_simd_nxt = in_simd_ctl;
                    if (is_mul_op(in_op)) begin
                        w_mul_s1_nxt    = w_simd_lanes ? in_s1 : {{XW{1'b0}}, in_s1[DATA_WIDTH-1:0]};
                        w_mul_s2_nxt    = w_simd_lanes ? in_s2 : {{XW{1'b0}}, in_s2[DATA_WIDTH-1:0]};
                        w_mul_sign_nxt  = mul_sign_of(in_op);
                        w_mul_start_nxt = 1'b1;
                        w_cnt_nxt       = CW'(MUL_LAT);
                        w_state_nxt     = ST_MUL_WAIT;
                    end else if (is_div_op(in_op)) begin
                        if (w_div_zero) begin
                            w_result_nxt = is_rem_op(in_op) ? {{XW{1'b0}}, in_s1[DATA_WIDTH-1:0]} :
                                                              {{XW{1'b0}}, {DATA_WIDTH{1'b1}}};
                            w_state_nxt  = ST_DONE;
                        end else if (w_div_ovf) begin
                            w_result_nxt = is_rem_op(in_op) ? '0 : {{XW{1'b0}}, in_s1[DATA_WIDTH-1:0]};
                            w_state_nxt  = ST_DONE;
                        end else begin
                            w_div_s1_nxt    = w_div_a;
                            w_div_s2_nxt    = w_div_b;
                            w_div_start_nxt = 1'b1;
                            w_state_nxt     = ST_DIV_WAIT;
                        end
                    end else begin
                        w_result_nxt = '0;
                        w_state_nxt  = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL_WAIT: begin
                if (r_cnt == '0) begin
                    w_result_nxt   = w_packed;
                    w_mul_s1_nxt   = '0;
                    w_mul_s2_nxt   = '0;
                    w_mul_sign_nxt = 2'b00;
                    w_state_nxt    = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_DIV_WAIT: begin
                if (div_done) begin
                    w_result_nxt = {{XW{1'b0}}, w_div_sel[DATA_WIDTH-1:0]};
                    w_div_s1_nxt = '0;
                    w_div_s2_nxt = '0;
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_state_nxt = ST_DIV_WAIT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_result_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (flush) begin
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = '0;
            w_mul_s1_nxt    = '0;
            w_mul_s2_nxt    = '0;
            w_mul_sign_nxt  = 2'b00;
            w_mul_start_nxt = 1'b0;
            w_div_s1_nxt    = '0;
            w_div_s2_nxt    = '0;
            w_div_start_nxt = 1'b0;
            w_result_nxt    = '0;
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= 4'd0;
            r_simd      <= 2'b00;
            r_mul_s1    <= '0;
            r_mul_s2    <= '0;
            r_mul_sign  <= 2'b00;
            r_mul_start <= 1'b0;
            r_div_s1    <= '0;
            r_div_s2    <= '0;
            r_div_start <= 1'b0;
            r_result    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_simd      <= w_simd_nxt;
            r_mul_s1    <= w_mul_s1_nxt;
            r_mul_s2    <= w_mul_s2_nxt;
            r_mul_sign  <= w_mul_sign_nxt;
            r_mul_start <= w_mul_start_nxt;
            r_div_s1    <= w_div_s1_nxt;
            r_div_s2    <= w_div_s2_nxt;
            r_div_start <= w_div_start_nxt;
            r_result    <= w_result_nxt;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_result;
    assign mul_s1    = r_mul_s1;
    assign mul_s2    = r_mul_s2;
    assign mul_sign  = r_mul_sign;
    assign mul_start = r_mul_start;
    assign div_s1    = r_div_s1;
    assign div_s2    = r_div_s2;
    assign div_start = r_div_start;

endmodule
